palette_arbiter: RTL

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one palette ROM across N_REQ requesters; response one cycle after grant.
// Latency: 1 cycle grant->rsp; no backpressure on responses. Optional macro: PALETTE_ARB_RANGE_CHECK_EN.
module palette_arbiter #(
    parameter int N_REQ     = 4,
    parameter int AW        = 5,
    parameter int DW        = 24,
    parameter int PAL_DEPTH = 23,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    req_ready,
    output logic [AW-1:0]       pal_rd_addr,
    input  logic [DW-1:0]       pal_data,
    output logic                rsp_valid,
    output logic [IW-1:0]       rsp_id,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err
);

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic [AW-1:0]    win_addr;
    logic [AW-1:0]    rd_addr_next;
    logic [AW-1:0]    addr_q;
    logic             oob;
    logic             err_q;

    // Search from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        if (!Reset_n) found = 1'b0;
        if (found) grant[win] = 1'b1;
    end

    assign req_ready = grant;
    assign win_addr  = req_addr[win*AW +: AW];

`ifdef PALETTE_ARB_RANGE_CHECK_EN
    localparam logic [AW:0] DEPTH_W = (AW+1)'(PAL_DEPTH);
    assign oob          = found && ({1'b0, win_addr} >= DEPTH_W);
    // Out-of-range lookups read entry 0 and the colour is forced to black.
    assign rd_addr_next = oob ? '0 : win_addr;
    assign rsp_data     = err_q ? '0 : pal_data;
`else
    assign oob          = 1'b0;
    assign rd_addr_next = win_addr;
    assign rsp_data     = pal_data;
`endif

    // Hold the last address on idle cycles so the ROM input does not toggle.
    assign pal_rd_addr = found ? rd_addr_next : addr_q;
    assign rsp_err     = err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr    <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_valid <= found;
            err_q     <= oob;
            if (found) begin
                rr_ptr <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
                rsp_id <= win;
                addr_q <= rd_addr_next;
            end
        end
    end

endmodule
